// File: rtl/instr_fetch.sv
// ----------------------------------------------------------------------------
// instr_fetch
//
// Fetches 1- or 2-byte instructions from a synchronous, byte-wide instruction
// memory. The current pc is read from the PC block. Each instruction goes to
// decode with a valid/ready handshake. On every accept, a one-cycle pc_update
// pulse (with pc_inc2) is sent back to the PC block.
//
// Fetch sequence per instruction:
//   StAddr0 : drive pc on imem_addr and latch it as instr_pc
//   StByte0 : capture byte0 and drive pc+1 speculatively
//   StByte1 : capture byte1 (2-byte instructions only)
//   StValid : hold the instruction until decode accepts it
//
// Parameters:
//   LONG_MASK   mask applied to byte0 for long-instruction detection
//   LONG_MATCH  (byte0 & LONG_MASK) == LONG_MATCH marks a 2-byte instruction
//   PERF_W      width of the stall counter
//
// Ports:
//   clk          system clock; all state changes on the rising edge
//   reset        synchronous, active-high reset
//   pc           current PC value from the PC block
//   imem_addr    imem byte address; the data returns on the next cycle
//   imem_data    imem read data for the address driven on the previous cycle
//   flush        discard any in-flight fetch and restart from pc
//   instr_valid  instr / instr_pc / instr_len2 hold a valid instruction
//   instr_ready  decode accepts when instr_valid && instr_ready
//   instr        {byte0, byte1}; byte1 is 8'h00 for 1-byte instructions
//   instr_len2   the instruction is 2 bytes long
//   instr_pc     pc value the instruction was fetched from
//   pc_update    one-cycle pulse to the PC block on accept
//   pc_inc2      with pc_update, advance the PC by 2 instead of 1
//   stall_cnt    count of cycles with instr_valid && !instr_ready
//
// Build option:
//   FETCH_PERF_CNT_EN  When defined, stall_cnt is a saturating counter that
//                      only reset clears. When undefined, stall_cnt is
//                      tied to 0.
// ----------------------------------------------------------------------------
module instr_fetch #(
    parameter logic [7:0]  LONG_MASK  = 8'hE0,
    parameter logic [7:0]  LONG_MATCH = 8'hE0,
    parameter int unsigned PERF_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        pc,
    output logic [7:0]        imem_addr,
    input  logic [7:0]        imem_data,
    input  logic              flush,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [15:0]       instr,
    output logic              instr_len2,
    output logic [7:0]        instr_pc,
    output logic              pc_update,
    output logic              pc_inc2,
    output logic [PERF_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        StAddr0,
        StByte0,
        StByte1,
        StValid
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] byte0_q, byte0_d;
    logic [7:0] byte1_q, byte1_d;
    logic [7:0] instr_pc_q, instr_pc_d;
    logic       len2_q, len2_d;
    logic       accept;
    logic       is_long;

    // Decode the length from the raw memory data. The result is used only in StByte0.
    assign is_long = ((imem_data & LONG_MASK) == LONG_MATCH);

    // ------------------------------------------------------------------------
    // Next-state and address logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        byte0_d    = byte0_q;
        byte1_d    = byte1_q;
        instr_pc_d = instr_pc_q;
        len2_d     = len2_q;
        accept     = 1'b0;
        imem_addr  = pc;

        unique case (state_q)
            StAddr0: begin
                instr_pc_d = pc;
                state_d    = StByte0;
            end
            StByte0: begin
                // Speculative second-byte read. The 8-bit add wraps 8'hFF to 8'h00.
                imem_addr = pc + 8'd1;
                byte0_d   = imem_data;
                len2_d    = is_long;
                if (is_long) begin
                    state_d = StByte1;
                end else begin
                    byte1_d = 8'h00;
                    state_d = StValid;
                end
            end
            StByte1: begin
                byte1_d = imem_data;
                state_d = StValid;
            end
            StValid: begin
                if (instr_ready) begin
                    accept  = 1'b1;
                    state_d = StAddr0;
                end
            end
            default: begin
                state_d = StAddr0;
            end
        endcase

        // Flush overrides everything, including an accept in the same cycle.
        if (flush) begin
            state_d = StAddr0;
            accept  = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StAddr0;
            byte0_q    <= 8'h00;
            byte1_q    <= 8'h00;
            instr_pc_q <= 8'h00;
            len2_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte0_q    <= byte0_d;
            byte1_q    <= byte1_d;
            instr_pc_q <= instr_pc_d;
            len2_q     <= len2_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign instr_valid = (state_q == StValid);
    assign instr       = {byte0_q, byte1_q};
    assign instr_len2  = len2_q;
    assign instr_pc    = instr_pc_q;

    // Reset has priority, so a pending accept never reaches the PC block.
    assign pc_update   = accept && !reset;
    assign pc_inc2     = pc_update && len2_q;

    // ------------------------------------------------------------------------
    // Stall counter
    // ------------------------------------------------------------------------
`ifdef FETCH_PERF_CNT_EN
    logic [PERF_W-1:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (instr_valid && !instr_ready && !flush && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

    typedef struct {
        logic [7:0]  pc;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [15:0] instr;
        logic        len2;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  pc;
    logic [7:0]  imem_addr;
    logic [7:0]  imem_data;
    logic        flush;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic        instr_len2;
    logic [7:0]  instr_pc;
    logic        pc_update;
    logic        pc_inc2;
    logic [15:0] stall_cnt;

    logic [7:0]  mem [256];
    vec_t        sb [$];
    vec_t        vecs [7];
    int          n_pass  = 0;
    int          n_total = 0;

    always #5 clk = ~clk;

    // Synchronous byte-wide instruction memory.
    always @(posedge clk) imem_data <= mem[imem_addr];

    instr_fetch dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .flush       (flush),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_len2  (instr_len2),
        .instr_pc    (instr_pc),
        .pc_update   (pc_update),
        .pc_inc2     (pc_inc2),
        .stall_cnt   (stall_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Precondition: the DUT is in its address cycle.
    task automatic setup(input vec_t v, input bit push);
        logic [7:0] a1;
        a1 = v.pc + 8'd1;
        mem[v.pc] = v.b0;
        mem[a1]   = v.b1;
        pc        = v.pc;
        if (push) sb.push_back(v);
        #1;
        check("addr0_imem_addr", imem_addr, v.pc);
    endtask

    task automatic wait_valid(output int edges);
        edges = 0;
        while (!instr_valid && edges < 12) begin
            tick();
            #1;
            edges++;
        end
        check("valid_seen", instr_valid, 1);
    endtask

    task automatic check_front();
        vec_t e;
        check("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("instr", instr, e.instr);
            check("instr_len2", instr_len2, e.len2);
            check("instr_pc", instr_pc, e.pc);
        end
    endtask

    task automatic run_one(input vec_t v);
        int edges;
        instr_ready = 1'b1;
        setup(v, 1'b1);
        wait_valid(edges);
        check("latency", edges, v.len2 ? 3 : 2);
        check_front();
        check("pc_update", pc_update, 1);
        check("pc_inc2", pc_inc2, v.len2);
        tick();
        #1;
        check("bubble_valid", instr_valid, 0);
        check("bubble_pc_update", pc_update, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, instr_valid, 0);
        check({tag, "_instr"}, instr, 0);
        check({tag, "_len2"}, instr_len2, 0);
        check({tag, "_instr_pc"}, instr_pc, 0);
        check({tag, "_pc_update"}, pc_update, 0);
        check({tag, "_pc_inc2"}, pc_inc2, 0);
        check({tag, "_stall_cnt"}, stall_cnt, 0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int   edges;
        vec_t v;
        logic [15:0] exp_stall;

`ifdef FETCH_PERF_CNT_EN
        exp_stall = 16'd5;
`else
        exp_stall = 16'd0;
`endif

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        vecs[0] = '{8'h00, 8'h12, 8'h99, 16'h1200, 1'b0};
        vecs[1] = '{8'h04, 8'hE5, 8'h7A, 16'hE57A, 1'b1};
        vecs[2] = '{8'hFF, 8'hE0, 8'h33, 16'hE033, 1'b1};
        vecs[3] = '{8'h10, 8'h1F, 8'h55, 16'h1F00, 1'b0};
        vecs[4] = '{8'h20, 8'hFF, 8'h01, 16'hFF01, 1'b1};
        vecs[5] = '{8'h30, 8'hC0, 8'hAA, 16'hC000, 1'b0};
        vecs[6] = '{8'h41, 8'hF3, 8'h00, 16'hF300, 1'b1};

        reset       = 1'b1;
        flush       = 1'b0;
        instr_ready = 1'b0;
        pc          = 8'h00;
        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b0;

        foreach (vecs[i]) run_one(vecs[i]);

        // Decode is not ready for five cycles, so the instruction must hold.
        v = '{8'h50, 8'h07, 8'h99, 16'h0700, 1'b0};
        instr_ready = 1'b0;
        setup(v, 1'b1);
        wait_valid(edges);
        check_front();
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", instr_valid, 1);
            check("hold_instr", instr, 16'h0700);
            check("hold_pc_update", pc_update, 0);
            tick();
            #1;
        end
        check("stall_cnt", stall_cnt, exp_stall);
        instr_ready = 1'b1;
        #1;
        check("hold_accept", pc_update, 1);
        tick();
        #1;

        // Flush and ready arrive in the same cycle; the flush wins.
        v = '{8'h60, 8'hE1, 8'h2B, 16'hE12B, 1'b1};
        instr_ready = 1'b1;
        setup(v, 1'b1);
        wait_valid(edges);
        check_front();
        flush = 1'b1;
        #1;
        check("flush_pc_update", pc_update, 0);
        check("flush_pc_inc2", pc_inc2, 0);
        tick();
        flush = 1'b0;
        #1;
        check("flush_valid_drop", instr_valid, 0);
        check("flush_pc_update_after", pc_update, 0);
        run_one(v);

        // Reset is asserted while the second byte is being fetched.
        v = '{8'h70, 8'hE8, 8'h44, 16'hE844, 1'b1};
        setup(v, 1'b0);
        tick();
        #1;
        check("byte0_imem_addr", imem_addr, 8'h71);
        tick();
        #1;
        check("byte1_imem_addr", imem_addr, 8'h70);
        check("byte1_valid", instr_valid, 0);
        reset = 1'b1;
        #1;
        check("reset_pc_update", pc_update, 0);
        tick();
        #1;
        check_all_zero("midreset");
        reset = 1'b0;
        run_one(v);

        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
